regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-read-port integer register file with synchronous, write-first bypassed reads and an integrated pending-write scoreboard. It sits in the decode/issue stage. It supplies operands to the execute stage one cycle after the address is presented. It also flags operands whose producing instruction has not yet written back, which lets issue logic stall.

## Interface
Parameters:
- XLEN, 32, register width in bits
- NREGS, 32, number of architectural registers (power of two, ≥2); AW = $clog2(NREGS) is a derived localparam
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and scoreboard sets

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- reg_rd_en_i  in  NRD  per-port read enable
- reg_rd_addr_i  in  NRD*AW  read addresses, port p at bits [p*AW +: AW]
- reg_rd_data_o  out  NRD*XLEN  registered read data, port p at [p*XLEN +: XLEN]
- reg_rd_busy_o  out  NRD  registered pending flag for the register captured on port p
- reg_wr_en_i  in  1  writeback enable
- reg_wr_addr_i  in  AW  writeback address
- reg_wr_data_i  in  XLEN  writeback data
- sb_set_i  in  1  mark sb_set_addr_i as pending (instruction issued)
- sb_set_addr_i  in  AW  destination register of the issued instruction
- sb_flush_i  in  1  clear all pending bits (pipeline flush)

## Operation
- Storage: NREGS x XLEN flops. All registers, all pending bits, reg_rd_data_o and reg_rd_busy_o are 0 during and after reset.
- Write: on a clock edge with reg_wr_en_i=1, x[reg_wr_addr_i] <= reg_wr_data_i. The write is dropped when ZERO_REG=1 and the address is 0.
- Read (per port, independent):
  - With reg_rd_en_i[p]=1, the port captures x[addr] at the edge.
  - Bypass: if a valid (non-dropped) write targets the same address in the same cycle, the port captures reg_wr_data_i (write-first).
  - ZERO_REG=1 and addr=0: the port captures 0 and busy 0.
  - With reg_rd_en_i[p]=0, data and busy outputs hold their values.
- Scoreboard: one pending bit per register. The next value per register is computed in priority order:
  1. sb_flush_i=1 → 0 for every register.
  2. sb_set_i=1 and addr match → 1. A set and a write to the same register in the same cycle leave it pending, because the new producer supersedes the old one.
  3. Valid write with addr match → 0.
  4. Otherwise hold.
- Busy capture: reg_rd_busy_o[p] captures the post-update pending bit for the addressed register, so it stays coherent with the bypassed data.
  - A read in the writeback cycle returns busy=0 and the new data.
  - A read in a sb_set_i cycle returns busy=1.
- Sets targeting register 0 are ignored when ZERO_REG=1.
- Multiple ports may read the same address; all ports see identical data and busy values.

## Timing
- Read latency: 1 cycle. Address and enable at edge N give data and busy valid after edge N, stable for all of cycle N+1.
- Write latency: 1 cycle to the array; zero extra through the bypass.
- Scoreboard set/clear takes effect at the edge. A read issued in the same cycle sees the effect through busy capture.
- Reset mid-operation: asynchronous assertion clears the array, the scoreboard and all outputs immediately. The first edge after deassertion behaves as normal operation.
- No combinational path from any input to any output.

## Structure
- regfile_pkg: default XLEN/NREGS constants and ZERO_ADDR.
- Sub-module regfile_sb holds the pending bits. Its inputs are set, flush and writeback. It exposes the NREGS-wide next-state vector used for busy capture.
- The top level holds the array, the bypass muxes and the per-port output registers, built with a generate loop over NRD.

## Test plan
- Reset, then read x5 and x31 on ports 0/1 → data 0, busy 0. Write x5=0xDEADBEEF, read x5 the next cycle → 0xDEADBEEF.
- Same cycle: write x7=0x12345678 and read x7 on both ports → both ports show 0x12345678 one cycle later.
- Write x0=0xFFFFFFFF, set x0 pending, read x0 → data 0, busy 0. With ZERO_REG=0 the same sequence → 0xFFFFFFFF, busy 1.
- Set x3 pending, then read x3 → busy 1. Write x3=0xA5 and read x3 in the same cycle → data 0xA5, busy 0. Set x3 and write x3 in the same cycle → busy 1 afterwards.
- Set x4, x9 and x12 pending, then assert sb_flush_i together with sb_set_i on x9 → all pending bits 0. Hold reg_rd_en_i low → outputs unchanged.
- Write x10=0x55 and set x11, then assert rst_n low mid-cycle → outputs immediately 0. After release, x10 reads 0 and x11 reads busy 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and constants for the multi-port register file
// Holds the default register width and count used as parameter defaults,
// and the address of the hardwired zero register.
package regfile_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_ADDR = 0;
endpackage

// File: rtl/regfile_sb.sv
// regfile_sb: pending-write scoreboard, one bit per architectural register
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   set_i, set_addr_i   mark a destination register pending at issue
//   flush_i             clear every pending bit
//   wr_en_i, wr_addr_i  qualified writeback (already masked for register 0)
//   pend_d_o            next-state pending vector, used for busy capture
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_i,
    input  logic [AW-1:0]    set_addr_i,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    output logic [NREGS-1:0] pend_d_o
);
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic             set_v;

    assign set_v = set_i && !(ZERO_REG != 0 && set_addr_i == AW'(ZERO_ADDR));

    // Flush beats set beats writeback: a new producer issued in the writeback
    // cycle supersedes the one that is retiring.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NREGS; i++)
            pend_d[i] = flush_i                           ? 1'b0 :
                        (set_v && set_addr_i == AW'(i))   ? 1'b1 :
                        (wr_en_i && wr_addr_i == AW'(i))  ? 1'b0 : pend_q[i];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;

    assign pend_d_o = pend_d;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with write-first bypass and scoreboard
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   reg_rd_en_i/reg_rd_addr_i        per-port read enable and address (AW bits each)
//   reg_rd_data_o/reg_rd_busy_o      registered read data and pending flag per port
//   reg_wr_en_i/addr_i/data_i        writeback port
//   sb_set_i/sb_set_addr_i           mark an issued destination pending
//   sb_flush_i                       clear all pending bits
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD-1:0]      reg_rd_en_i,
    input  logic [NRD*AW-1:0]   reg_rd_addr_i,
    output logic [NRD*XLEN-1:0] reg_rd_data_o,
    output logic [NRD-1:0]      reg_rd_busy_o,
    input  logic                reg_wr_en_i,
    input  logic [AW-1:0]       reg_wr_addr_i,
    input  logic [XLEN-1:0]     reg_wr_data_i,
    input  logic                sb_set_i,
    input  logic [AW-1:0]       sb_set_addr_i,
    input  logic                sb_flush_i
);
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] pend_d;
    logic             wr_v;

    // Writes to the hardwired zero register are dropped everywhere, including the bypass.
    assign wr_v = reg_wr_en_i && !(ZERO_REG != 0 && reg_wr_addr_i == AW'(ZERO_ADDR));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        else if (wr_v) regs_q[reg_wr_addr_i] <= reg_wr_data_i;

    regfile_sb #(.NREGS(NREGS), .ZERO_REG(ZERO_REG)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_i      (sb_set_i),
        .set_addr_i (sb_set_addr_i),
        .flush_i    (sb_flush_i),
        .wr_en_i    (wr_v),
        .wr_addr_i  (reg_wr_addr_i),
        .pend_d_o   (pend_d)
    );

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            zero;
        logic [XLEN-1:0] data_d, data_q;
        logic            busy_d, busy_q;
        assign addr   = reg_rd_addr_i[p*AW +: AW];
        assign zero   = ZERO_REG != 0 && addr == AW'(ZERO_ADDR);
        assign data_d = zero                           ? '0 :
                        (wr_v && reg_wr_addr_i == addr) ? reg_wr_data_i : regs_q[addr];
        // Busy uses the post-update pending bit so it matches the bypassed data.
        assign busy_d = !zero && pend_d[addr];
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                data_q <= '0;
                busy_q <= 1'b0;
            end else if (reg_rd_en_i[p]) begin
                data_q <= data_d;
                busy_q <= busy_d;
            end
        assign reg_rd_data_o[p*XLEN +: XLEN] = data_q;
        assign reg_rd_busy_o[p]              = busy_q;
    end
endmodule
